mips_muldiv_unit: RTL and testbench

Iterative multiply/divide unit sitting beside the execute stage of the 32-bit MIPS core. It consumes MULT/MULTU/DIV/DIVU operands read from mips_register and produces the HI/LO pair. The core routes that pair into the register file's dual write ports (writeData1/writeReg1, writeData2/writeReg2). The unit is multi-cycle: the core stalls PC on busy.

---
 rtl/mips_pkg.sv | 20 ++
 rtl/mips_muldiv_datapath.sv | 54 +++++
 rtl/mips_muldiv_unit.sv | 163 ++++++++++++++++
 tb/tb_mips_muldiv_unit.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS multiply/divide unit: operation codes,
// controller states and the default operand width.
package mips_pkg;

   localparam int WIDTH = 32;

   typedef enum logic [1:0] {
      MD_MULT  = 2'b00,
      MD_MULTU = 2'b01,
      MD_DIV   = 2'b10,
      MD_DIVU  = 2'b11
   } md_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_SIGN = 2'b10
   } md_state_e;

endpackage

// File: rtl/mips_muldiv_datapath.sv
// Iteration datapath for the multiply/divide unit. A 2*WIDTH accumulator
// holds {upper, lower} words: for multiply it is {partial product, multiplier},
// for divide it is {remainder, dividend/quotient}. One step per enabled clock.
module mips_muldiv_datapath #(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 i_load,
   input  logic [2*WIDTH-1:0]   i_loadAcc,
   input  logic [WIDTH-1:0]     i_loadOperand,
   input  logic                 i_step,
   input  logic                 i_isDiv,
   output logic [2*WIDTH-1:0]   o_acc
);

   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_operand;
   logic [WIDTH:0]     w_mulSum;
   logic [WIDTH:0]     w_divDiff;
   logic [2*WIDTH-1:0] w_next;

   // Compute the next accumulator value for one shift-add or restoring-divide iteration
   always_comb begin
      w_mulSum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_operand} : '0);
      w_divDiff = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_operand};
      w_next    = r_acc;
      if (i_isDiv) begin
         if (!w_divDiff[WIDTH]) begin
            w_next = {w_divDiff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
         end else begin
            w_next = {r_acc[2*WIDTH-2:0], 1'b0};
         end
      end else begin
         w_next = {w_mulSum, r_acc[WIDTH-1:1]};
      end
   end

   // Load fresh operands on acceptance, otherwise advance one iteration when stepping
   always_ff @(posedge clk) begin
      if (reset) begin
         r_acc     <= '0;
         r_operand <= '0;
      end else if (i_load) begin
         r_acc     <= i_loadAcc;
         r_operand <= i_loadOperand;
      end else if (i_step) begin
         r_acc     <= w_next;
      end
   end

   assign o_acc = r_acc;

endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit. Operands are reduced to magnitudes on
// acceptance, WIDTH iterations run in the datapath, and a final sign-fix cycle
// writes HI/LO and pulses done. Divide by zero skips the iterations entirely.
module mips_muldiv_unit
   import mips_pkg::*;
#(
   parameter int WIDTH = mips_pkg::WIDTH,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_zero
);

   md_state_e          r_state;
   md_op_e             r_op;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_signQ;
   logic               r_signR;
   logic               r_divZero;
   logic               r_busy;
   logic               r_done;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;

   md_op_e             w_op;
   logic               w_reqSigned;
   logic               w_reqDiv;
   logic               w_reqDivZero;
   logic               w_accept;
   logic [WIDTH-1:0]   w_absA;
   logic [WIDTH-1:0]   w_absB;
   logic [2*WIDTH-1:0] w_loadAcc;
   logic [WIDTH-1:0]   w_loadOperand;
   logic [2*WIDTH-1:0] w_acc;
   logic [2*WIDTH-1:0] w_negAcc;
   logic               w_runSigned;
   logic               w_runDiv;
   logic [WIDTH-1:0]   w_hiNext;
   logic [WIDTH-1:0]   w_loNext;

   assign w_op         = md_op_e'(op);
   assign w_reqSigned  = (w_op == MD_MULT) || (w_op == MD_DIV);
   assign w_reqDiv     = (w_op == MD_DIV)  || (w_op == MD_DIVU);
   assign w_reqDivZero = w_reqDiv && (b == '0);
   assign w_accept     = (r_state == S_IDLE) && start;
   assign w_runSigned  = (r_op == MD_MULT) || (r_op == MD_DIV);
   assign w_runDiv     = (r_op == MD_DIV)  || (r_op == MD_DIVU);
   assign w_negAcc     = -w_acc;

   // Form operand magnitudes and the initial accumulator image for the datapath
   always_comb begin
      w_absA = (w_reqSigned && a[WIDTH-1]) ? -a : a;
      w_absB = (w_reqSigned && b[WIDTH-1]) ? -b : b;
      if (w_reqDivZero) begin
         w_loadAcc     = {a, {WIDTH{1'b1}}};
         w_loadOperand = '0;
      end else if (w_reqDiv) begin
         w_loadAcc     = {{WIDTH{1'b0}}, w_absA};
         w_loadOperand = w_absB;
      end else begin
         w_loadAcc     = {{WIDTH{1'b0}}, w_absB};
         w_loadOperand = w_absA;
      end
   end

   mips_muldiv_datapath #(
      .WIDTH(WIDTH)
   ) u_datapath (
      .clk           (clk),
      .reset         (reset),
      .i_load        (w_accept),
      .i_loadAcc     (w_loadAcc),
      .i_loadOperand (w_loadOperand),
      .i_step        (r_state == S_RUN),
      .i_isDiv       (w_runDiv),
      .o_acc         (w_acc)
   );

   // Apply the two's-complement correction to the unsigned iteration result
   always_comb begin
      w_hiNext = w_acc[2*WIDTH-1:WIDTH];
      w_loNext = w_acc[WIDTH-1:0];
      if (!r_divZero && w_runSigned) begin
         if (!w_runDiv) begin
            if (r_signQ) begin
               w_hiNext = w_negAcc[2*WIDTH-1:WIDTH];
               w_loNext = w_negAcc[WIDTH-1:0];
            end
         end else begin
            if (r_signQ) begin
               w_loNext = -w_acc[WIDTH-1:0];
            end
            if (r_signR) begin
               w_hiNext = -w_acc[2*WIDTH-1:WIDTH];
            end
         end
      end
   end

   // Controller: accept in IDLE, count iterations in RUN, publish results in SIGN
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_op      <= MD_MULT;
         r_cnt     <= '0;
         r_signQ   <= 1'b0;
         r_signR   <= 1'b0;
         r_divZero <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_hi      <= '0;
         r_lo      <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_op      <= w_op;
                  r_signQ   <= a[WIDTH-1] ^ b[WIDTH-1];
                  r_signR   <= a[WIDTH-1];
                  r_divZero <= w_reqDivZero;
                  r_cnt     <= '0;
                  r_busy    <= 1'b1;
                  r_state   <= w_reqDivZero ? S_SIGN : S_RUN;
               end
            end
            S_RUN: begin
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == CNT_W'(WIDTH - 1)) begin
                  r_state <= S_SIGN;
               end
            end
            S_SIGN: begin
               r_hi    <= w_hiNext;
               r_lo    <= w_loNext;
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign busy     = r_busy;
   assign done     = r_done;
   assign hi       = r_hi;
   assign lo       = r_lo;
   assign div_zero = r_divZero;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Self-checking bench for mips_muldiv_unit: directed corner cases followed by
// random operations compared against an arithmetic reference model.
module tb_mips_muldiv_unit;

   logic        clk;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        div_zero;

   int errors;
   int checks;

   mips_muldiv_unit dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .op       (op),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .hi       (hi),
      .lo       (lo),
      .div_zero (div_zero)
   );

   // Free-running 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference results computed with plain integer arithmetic
   function automatic void refModel(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                    output logic [31:0] h, output logic [31:0] l, output logic z);
      longint          sp;
      longint unsigned up;
      int              sq;
      int              sr;
      z = 1'b0;
      h = '0;
      l = '0;
      case (o)
         2'b00: begin
            sp = longint'($signed(x)) * longint'($signed(y));
            h = sp[63:32];
            l = sp[31:0];
         end
         2'b01: begin
            up = {32'h0, x} * {32'h0, y};
            h = up[63:32];
            l = up[31:0];
         end
         2'b10: begin
            if (y == 0) begin
               h = x; l = 32'hFFFFFFFF; z = 1'b1;
            end else if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin
               h = 32'h0; l = 32'h80000000;
            end else begin
               sq = $signed(x) / $signed(y);
               sr = $signed(x) % $signed(y);
               h = sr;
               l = sq;
            end
         end
         default: begin
            if (y == 0) begin
               h = x; l = 32'hFFFFFFFF; z = 1'b1;
            end else begin
               h = x % y;
               l = x / y;
            end
         end
      endcase
   endfunction

   // One comparison: counts it, and counts and reports a miss
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Drive a one-cycle start request, beginning at the current falling edge
   task automatic applyStimulus(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
   endtask

   // Wait for done; scrambles operands after acceptance to prove they were latched
   task automatic waitDone(output int lat, output int busyCycles);
      lat = 0;
      busyCycles = 0;
      while (lat < 100) begin
         @(negedge clk);
         lat++;
         if (lat == 1) begin
            start = 1'b0;
            op    = 2'($urandom);
            a     = $urandom;
            b     = $urandom;
         end
         if (done) break;
         if (busy) busyCycles++;
      end
   endtask

   // Full operation: start, wait, compare latency and results against the model
   task automatic doOp(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      int          lat;
      int          busyCycles;
      logic [31:0] expHi;
      logic [31:0] expLo;
      logic        expZ;
      refModel(o, x, y, expHi, expLo, expZ);
      applyStimulus(o, x, y);
      waitDone(lat, busyCycles);
      checkOutput({tag, ".latency"}, 32'(lat), (o[1] && y == 0) ? 32'd2 : 32'd34);
      checkOutput({tag, ".hi"}, hi, expHi);
      checkOutput({tag, ".lo"}, lo, expLo);
      checkOutput({tag, ".divZero"}, {31'b0, div_zero}, {31'b0, expZ});
   endtask

   initial begin
      int          lat;
      int          busyCycles;
      int          doneCount;
      logic [31:0] holdHi;
      logic [1:0]  rOp;
      logic [31:0] rA;
      logic [31:0] rB;
      errors = 0;
      checks = 0;
      reset  = 1'b1;
      start  = 1'b0;
      op     = 2'b00;
      a      = '0;
      b      = '0;

      // Reset state
      repeat (3) @(negedge clk);
      checkOutput("reset.busy", {31'b0, busy}, 32'd0);
      checkOutput("reset.done", {31'b0, done}, 32'd0);
      checkOutput("reset.hi", hi, 32'd0);
      checkOutput("reset.lo", lo, 32'd0);
      checkOutput("reset.divZero", {31'b0, div_zero}, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // Unsigned max multiply with busy window and latency
      applyStimulus(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
      waitDone(lat, busyCycles);
      checkOutput("multuMax.latency", 32'(lat), 32'd34);
      checkOutput("multuMax.busyCycles", 32'(busyCycles), 32'd33);
      checkOutput("multuMax.busyAtDone", {31'b0, busy}, 32'd0);
      checkOutput("multuMax.hi", hi, 32'hFFFFFFFE);
      checkOutput("multuMax.lo", lo, 32'h00000001);

      // Results hold between operations
      holdHi = hi;
      repeat (3) @(negedge clk);
      checkOutput("hold.hi", hi, holdHi);
      checkOutput("hold.done", {31'b0, done}, 32'd0);

      // Signed and unsigned multiply / divide corners
      doOp("multNeg", 2'b00, 32'hFFFFFFFD, 32'd5);
      doOp("multPos", 2'b00, 32'd7, 32'd6);
      doOp("divNeg", 2'b10, 32'hFFFFFFF9, 32'd2);
      doOp("divu", 2'b11, 32'd100, 32'd7);
      doOp("divOverflow", 2'b10, 32'h80000000, 32'hFFFFFFFF);
      doOp("divuZero", 2'b11, 32'd123, 32'd0);
      doOp("divZeroClear", 2'b11, 32'd100, 32'd7);
      doOp("divZeroSigned", 2'b10, 32'hFFFFFF00, 32'd0);

      // Starts while busy are ignored; a start in the done cycle is accepted
      applyStimulus(2'b01, 32'd2, 32'd3);
      lat = 0;
      doneCount = 0;
      while (lat < 100 && doneCount == 0) begin
         @(negedge clk);
         lat++;
         start = (lat == 5 || lat == 20);
         op    = 2'b11;
         a     = 32'd1000;
         b     = 32'd10;
         if (done) doneCount++;
      end
      checkOutput("ignoreStart.latency", 32'(lat), 32'd34);
      checkOutput("ignoreStart.hi", hi, 32'd0);
      checkOutput("ignoreStart.lo", lo, 32'd6);
      applyStimulus(2'b11, 32'd9, 32'd3);
      waitDone(lat, busyCycles);
      checkOutput("doneCycleStart.latency", 32'(lat), 32'd34);
      checkOutput("doneCycleStart.hi", hi, 32'd0);
      checkOutput("doneCycleStart.lo", lo, 32'd3);

      // Reset mid-operation aborts without a done pulse
      applyStimulus(2'b00, 32'd5, 32'd7);
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         start = 1'b0;
      end
      reset = 1'b1;
      @(negedge clk);
      checkOutput("abort.busy", {31'b0, busy}, 32'd0);
      checkOutput("abort.hi", hi, 32'd0);
      checkOutput("abort.lo", lo, 32'd0);
      checkOutput("abort.done", {31'b0, done}, 32'd0);
      reset = 1'b0;
      doneCount = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) doneCount++;
      end
      checkOutput("abort.noDone", 32'(doneCount), 32'd0);
      doOp("afterAbort", 2'b00, 32'd4, 32'd4);

      // Randomized operations against the reference model
      for (int n = 0; n < 24; n++) begin
         rOp = 2'($urandom);
         rA  = $urandom;
         case ($urandom_range(0, 7))
            0:       rB = 32'd0;
            1:       rB = $urandom_range(1, 20);
            2:       rB = -($urandom_range(1, 20));
            default: rB = $urandom;
         endcase
         if ($urandom_range(0, 3) == 0) rA = $urandom_range(0, 1000);
         doOp($sformatf("rand%0d", n), rOp, rA, rB);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
